// File: rtl/compmag_seq.sv
// Sequential unsigned magnitude comparator: one shared 4-bit nibble
// compare per cycle, MSB nibble first, valid/ready on both sides.
module compmag_seq #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_dec;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic [WIDTH-1:0] w_sha;
  logic [WIDTH-1:0] w_shb;
  logic [3:0]       w_na;
  logic [3:0]       w_nb;
  logic             w_neq;
  logic             w_last;
  logic             w_acc;

  assign w_sha  = r_a >> {r_idx, 2'b00};
  assign w_shb  = r_b >> {r_idx, 2'b00};
  assign w_na   = w_sha[3:0];
  assign w_nb   = w_shb[3:0];
  assign w_neq  = (w_na != w_nb);
  assign w_last = (r_idx == '0);
  assign w_acc  = in_valid && (r_state == IDLE);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign aeqb      = r_eq;
  assign agtb      = r_gt;
  assign altb      = r_lt;

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_n = CMP;
      CMP: begin
        if ((EARLY_EXIT != 0) && w_neq) w_state_n = DONE;
        else if (w_last) w_state_n = DONE;
      end
      DONE: if (out_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // r_dec holds the first unequal-nibble decision so later nibbles
  // cannot overwrite it in the constant-latency mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_dec <= 1'b0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (w_acc) begin
      r_a   <= a;
      r_b   <= b;
      r_idx <= IW'(NIB - 1);
      r_dec <= 1'b0;
    end else if (r_state == CMP) begin
      if (!r_dec && w_neq) begin
        r_dec <= 1'b1;
        r_eq  <= 1'b0;
        r_gt  <= (w_na > w_nb);
        r_lt  <= (w_na < w_nb);
      end else if (!r_dec && w_last) begin
        r_eq  <= 1'b1;
        r_gt  <= 1'b0;
        r_lt  <= 1'b0;
      end
      if (!w_last) r_idx <= r_idx - 1'b1;
    end
  end

endmodule

// File: tb/tb_compmag_seq.sv
// Bench for compmag_seq: early-exit and constant-latency instances
// driven in parallel from a directed vector table.
module tb_compmag_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic ir1, ov1, eq1, gt1, lt1;
  logic ir0, ov0, eq0, gt0, lt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  compmag_seq #(.WIDTH(16), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready),
    .aeqb(eq1), .agtb(gt1), .altb(lt1)
  );

  compmag_seq #(.WIDTH(16), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready),
    .aeqb(eq0), .agtb(gt0), .altb(lt0)
  );

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [2:0]  fl;
    int          k1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [15:0] xa, input logic [15:0] xb,
                       input logic [15:0] pa, input logic [15:0] pb);
    @(negedge clk);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = pa;
    b = pb;
  endtask

  task automatic wait_done(input int k1);
    int l1, l0;
    l1 = 0;
    l0 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (l1 == 0 && ov1) l1 = c;
      if (l0 == 0 && ov0) l0 = c;
      if (l1 != 0 && l0 != 0) break;
    end
    chk("lat_ee1", l1, k1);
    chk("lat_ee0", l0, 4);
  endtask

  task automatic chk_flags(input logic [2:0] fl);
    chk("flags_ee1", {eq1, gt1, lt1}, fl);
    chk("flags_ee0", {eq0, gt0, lt0}, fl);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_ready", {ir1, ir0, ov1, ov0}, 4'b1100);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 3'b010, 1};
    vecs[1] = '{16'hBEEF, 16'hBEEF, 3'b100, 4};
    vecs[2] = '{16'h1230, 16'h1231, 3'b001, 4};
    vecs[3] = '{16'h8000, 16'h7FFF, 3'b010, 1};
    vecs[4] = '{16'h0000, 16'h0000, 3'b100, 4};
    vecs[5] = '{16'h1204, 16'h1234, 3'b001, 3};
    vecs[6] = '{16'hFFFF, 16'hFFFE, 3'b010, 4};
    vecs[7] = '{16'h0F00, 16'h00FF, 3'b010, 2};

    #2;
    chk("rst_state", {ir1, ov1, eq1, gt1, lt1}, 5'b10000);
    chk("rst_state0", {ir0, ov0, eq0, gt0, lt0}, 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].va, vecs[i].vb, vecs[i].va, vecs[i].vb);
      wait_done(vecs[i].k1);
      chk_flags(vecs[i].fl);
      release_out();
    end

    // Stall in DONE with in_valid and operands toggling.
    start(16'h1234, 16'h0234, 16'h1234, 16'h0234);
    wait_done(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 16'h0001 << i;
      b = 16'hFFFF;
      @(posedge clk);
      #1;
      chk("stall_vld", {ov1, ov0, ir1, ir0}, 4'b1100);
      chk_flags(3'b010);
    end
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stall_rel", {ir1, ir0, ov1, ov0}, 4'b1100);
    @(posedge clk);
    #1;
    chk("no_reaccept", {ir1, ir0, ov1, ov0}, 4'b1100);

    // Operands change right after accept; sampled values win.
    start(16'h00FF, 16'h0F00, 16'hFFFF, 16'h0F00);
    wait_done(2);
    chk_flags(3'b001);
    release_out();

    // Async reset in the second CMP cycle.
    start(16'h1234, 16'h1235, 16'h1234, 16'h1235);
    @(posedge clk);
    #1;
    chk("pre_rst", {ov1, ov0, ir1, ir0}, 4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {ir1, ov1, eq1, gt1, lt1}, 5'b10000);
    chk("async_rst0", {ir0, ov0, eq0, gt0, lt0}, 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    start(16'hA5A5, 16'hA5A4, 16'hA5A5, 16'hA5A4);
    wait_done(4);
    chk_flags(3'b010);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/compmag_seq.md
COMPMAG_SEQ -- requirements
Module: compmag_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4, minimum 4.
REQ-002 The block SHALL have parameter EARLY_EXIT, default 1; 1 = stop at first unequal nibble, 0 = always scan all nibbles for constant latency.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid  input  1  operand pair a/b present.
REQ-006 The block SHALL have port in_ready  output  1  block able to accept operands.
REQ-007 The block SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-008 The block SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-009 The block SHALL have port out_valid  output  1  result flags valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port aeqb  output  1  A equal to B.
REQ-012 The block SHALL have port agtb  output  1  A greater than B.
REQ-013 The block SHALL have port altb  output  1  A less than B.

Function
REQ-014 The block SHALL compare A and B as unsigned values through one shared 4-bit nibble comparison per cycle, MSB nibble first.
REQ-015 The FSM SHALL have exactly three states: IDLE, CMP and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in all other states, in_ready SHALL be 0.
REQ-017 An input handshake (in_valid & in_ready at a rising edge) SHALL register a and b, set the nibble index to WIDTH/4-1, and move the FSM to CMP.
REQ-018 Operands SHALL be sampled only on the input handshake; later changes on a/b SHALL NOT affect the result.
REQ-019 In CMP, each cycle SHALL compare registered nibble [4*idx+3:4*idx] of A against the same nibble of B.
REQ-020 With EARLY_EXIT=1, an unequal nibble SHALL set agtb or altb per that nibble, clear aeqb, and move the FSM to DONE on that edge.
REQ-021 With EARLY_EXIT=1, an equal nibble at idx=0 SHALL set aeqb=1 and move the FSM to DONE; an equal nibble at idx>0 SHALL decrement idx.
REQ-022 With EARLY_EXIT=0, the first unequal nibble SHALL latch the decision, remaining nibbles SHALL NOT change it, and DONE SHALL be entered only after idx=0 is processed.
REQ-023 Latency from the handshake edge to out_valid=1 SHALL be k cycles, where k = number of nibbles examined (1..WIDTH/4); with EARLY_EXIT=0, k SHALL always be WIDTH/4.
REQ-024 In DONE, out_valid SHALL be 1 and exactly one of aeqb/agtb/altb SHALL be 1.
REQ-025 aeqb, agtb and altb SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 An output handshake (out_valid & out_ready) SHALL move the FSM DONE->IDLE; in_ready SHALL be 1 in the following cycle, with no same-cycle re-accept.
REQ-027 Result flags SHALL retain their last values after leaving DONE and SHALL be qualified only by out_valid.
REQ-028 in_valid asserted during CMP or DONE SHALL be ignored.
REQ-029 For WIDTH=4, the block SHALL need exactly one CMP cycle.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock edge, force the FSM to IDLE and drive out_valid=0, aeqb=0, agtb=0, altb=0, and idx=0.
REQ-031 Reset asserted mid-CMP or in DONE SHALL abort the operation with no result produced.
REQ-032 After rst_n deasserts, the first edge SHALL be able to accept operands, with in_ready=1.

Verification (WIDTH=16 unless noted)
REQ-033 Bench SHALL cover: a=0x1234, b=0x0234, EARLY_EXIT=1 -> out_valid 1 cycle after accept, agtb=1, aeqb=0, altb=0.
REQ-034 Bench SHALL cover: a=b=0xBEEF -> out_valid 4 cycles after accept, aeqb=1; same a=0x1234/b=0x0234 case with EARLY_EXIT=0 -> 4 cycles, agtb=1.
REQ-035 Bench SHALL cover: a=0x1230, b=0x1231 -> 4 cycles, altb=1; a=0x8000, b=0x7FFF -> 1 cycle, agtb=1.
REQ-036 Bench SHALL cover: out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b -> flags stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-037 Bench SHALL cover: a/b changed the cycle after accept (a=0x00FF->0xFFFF, b=0x0F00) -> result altb=1 from the sampled values.
REQ-038 Bench SHALL cover: rst_n=0 pulsed in the 2nd CMP cycle -> outputs 0 and in_ready=1 without a clock edge; a fresh compare afterward is correct.
